// File: rtl/vga_pixel_pipe_pkg.sv
// Shared definitions for the VGA pixel pipeline: game-state codes, colour
// constants, fade controller state type and the per-channel shading function.
package vga_pixel_pipe_pkg;

  localparam logic [3:0] TITLE     = 4'd0;
  localparam logic [3:0] PLAY      = 4'd1;
  localparam logic [3:0] PAUSE     = 4'd2;
  localparam logic [3:0] GAME_OVER = 4'd3;
  localparam logic [3:0] WIN       = 4'd4;
  localparam logic [3:0] HELP      = 4'd5;

  localparam logic [11:0] TRANSPARENT = 12'hF0F;
  localparam logic [3:0]  FADE_MAX    = 4'd15;
  localparam int          DARK_SHIFT  = 1;

  typedef enum logic [1:0] {
    FADE_IDLE = 2'd0,
    FADE_OUT  = 2'd1,
    FADE_IN   = 2'd2
  } fade_state_t;

  // Darken (optional halving) then subtract the fade level, clamped at black.
  function automatic logic [3:0] shade_chan(input logic [3:0] c,
                                            input logic       dark,
                                            input logic [3:0] lvl);
    logic [3:0] d;
    d = dark ? (c >> DARK_SHIFT) : c;
    return (d > lvl) ? (d - lvl) : 4'd0;
  endfunction

endpackage

// File: rtl/vga_fade_ctrl.sv
// Screen fade controller: ramps a 4-bit darkening level out and back in,
// one step per frame, whenever the game state changes.
module vga_fade_ctrl
  import vga_pixel_pipe_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  input  logic       vsync_in,
  input  logic [3:0] state,
  output logic [3:0] level,
  output logic       busy
);

  fade_state_t r_fsm, w_fsm_next;
  logic [3:0]  r_level, w_level_next;
  logic [3:0]  r_state, r_prev_state;
  logic        r_vs_prev;
  logic        w_frame_tick, w_state_chg;

  assign w_frame_tick = pix_en & r_vs_prev & ~vsync_in;
  assign w_state_chg  = pix_en & (r_state != r_prev_state);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm        <= FADE_IDLE;
      r_level      <= 4'd0;
      r_state      <= TITLE;
      r_prev_state <= TITLE;
      r_vs_prev    <= 1'b0;
    end else begin
      r_fsm   <= w_fsm_next;
      r_level <= w_level_next;
      if (pix_en) begin
        r_prev_state <= r_state;
        r_state      <= state;
        r_vs_prev    <= vsync_in;
      end
    end
  end

  // The turnaround tick at full darkness also takes the first step back
  // down, so a complete out-and-in fade spans 31 frames.
  always_comb begin
    w_fsm_next   = r_fsm;
    w_level_next = r_level;
    case (r_fsm)
      FADE_IDLE: begin
        w_level_next = 4'd0;
        if (w_state_chg) w_fsm_next = FADE_OUT;
      end
      FADE_OUT: begin
        if (w_frame_tick) begin
          if (r_level == FADE_MAX) begin
            w_fsm_next   = FADE_IN;
            w_level_next = FADE_MAX - 4'd1;
          end else begin
            w_level_next = r_level + 4'd1;
          end
        end
      end
      FADE_IN: begin
        if (w_state_chg) begin
          w_fsm_next = FADE_OUT;
        end else if (w_frame_tick) begin
          if (r_level == 4'd0) w_fsm_next = FADE_IDLE;
          else                 w_level_next = r_level - 4'd1;
        end
      end
      default: begin
        w_fsm_next   = FADE_IDLE;
        w_level_next = 4'd0;
      end
    endcase
  end

  assign level = r_level;
  assign busy  = (r_fsm != FADE_IDLE);

endmodule

// File: rtl/vga_pixel_pipe.sv
// Two-stage VGA colour pipeline (ROM address, then colour/sync outputs).
// Define VGA_PIXEL_PIPE_FADE_EN to include the screen-fade controller.
module vga_pixel_pipe
  import vga_pixel_pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  input  logic        valid,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [16:0] pixel_addr,
  input  logic        notBlank,
  input  logic        isDark,
  input  logic [3:0]  state,
  output logic [16:0] rom_addr,
  input  logic [11:0] rom_data,
  output logic [3:0]  vgaRed,
  output logic [3:0]  vgaGreen,
  output logic [3:0]  vgaBlue,
  output logic        hsync,
  output logic        vsync,
  output logic        fade_busy
);

  logic [16:0] r_rom_addr;
  logic        r_a_valid, r_a_notblank, r_a_dark, r_a_hs, r_a_vs;
  logic [11:0] r_rgb;
  logic        r_hs, r_vs;
  logic [3:0]  w_level;
  logic        w_busy;
  logic [11:0] w_shaded, w_rgb_next;
  logic        w_blank;

`ifdef VGA_PIXEL_PIPE_FADE_EN
  vga_fade_ctrl u_fade (
    .clk      (clk),
    .rst      (rst),
    .pix_en   (pix_en),
    .vsync_in (vsync_in),
    .state    (state),
    .level    (w_level),
    .busy     (w_busy)
  );
`else
  logic w_unused_state;
  assign w_unused_state = ^state;
  assign w_level        = 4'd0;
  assign w_busy         = 1'b0;
`endif

  // Stage A: address the ROM and carry the sidebands alongside it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rom_addr   <= 17'd0;
      r_a_valid    <= 1'b0;
      r_a_notblank <= 1'b0;
      r_a_dark     <= 1'b0;
      r_a_hs       <= 1'b1;
      r_a_vs       <= 1'b1;
    end else if (pix_en) begin
      r_rom_addr   <= pixel_addr;
      r_a_valid    <= valid;
      r_a_notblank <= notBlank;
      r_a_dark     <= isDark;
      r_a_hs       <= hsync_in;
      r_a_vs       <= vsync_in;
    end
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : gen_chan
      assign w_shaded[gi*4 +: 4] = shade_chan(rom_data[gi*4 +: 4], r_a_dark, w_level);
    end
  endgenerate

  assign w_blank    = ~r_a_valid | ~r_a_notblank | (rom_data == TRANSPARENT);
  assign w_rgb_next = w_blank ? 12'h000 : w_shaded;

  // Stage B: ROM data has settled; register final colour and syncs together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rgb <= 12'h000;
      r_hs  <= 1'b1;
      r_vs  <= 1'b1;
    end else if (pix_en) begin
      r_rgb <= w_rgb_next;
      r_hs  <= r_a_hs;
      r_vs  <= r_a_vs;
    end
  end

  assign rom_addr  = r_rom_addr;
  assign vgaRed    = r_rgb[11:8];
  assign vgaGreen  = r_rgb[7:4];
  assign vgaBlue   = r_rgb[3:0];
  assign hsync     = r_hs;
  assign vsync     = r_vs;
  assign fade_busy = w_busy;

endmodule

// File: tb/tb_vga_pixel_pipe.sv
// Self-checking bench for vga_pixel_pipe: scoreboard of expected pixels,
// ROM modelled as a registered-read memory, independent fade model.
module tb_vga_pixel_pipe;

  logic        clk = 1'b0;
  logic        rst, pix_en, valid, hsync_in, vsync_in, notBlank, isDark;
  logic [16:0] pixel_addr, rom_addr;
  logic [3:0]  state;
  logic [11:0] rom_data;
  logic [3:0]  vgaRed, vgaGreen, vgaBlue;
  logic        hsync, vsync, fade_busy;

  vga_pixel_pipe dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .valid(valid),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .pixel_addr(pixel_addr),
    .notBlank(notBlank), .isDark(isDark), .state(state),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .vgaRed(vgaRed), .vgaGreen(vgaGreen), .vgaBlue(vgaBlue),
    .hsync(hsync), .vsync(vsync), .fade_busy(fade_busy)
  );

  always #5 clk = ~clk;

  logic [11:0] rom_mem [0:255];
  always @(posedge clk) rom_data <= rom_mem[rom_addr[7:0]];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
  } exp_t;
  exp_t sb[$];

  int          m_fs;
  logic [3:0]  m_L, m_rs, m_rps;
  logic        m_vsp;
  logic [16:0] next_addr;

  function automatic logic [11:0] model_rgb(input logic [11:0] d, input logic v,
                                            input logic nb, input logic dk,
                                            input logic [3:0] lvl);
    logic [11:0] r;
    logic [3:0]  c;
    if (!v || !nb || d == 12'hF0F) return 12'h000;
    for (int i = 0; i < 3; i++) begin
      c = d[i*4 +: 4];
      if (dk) c = {1'b0, c[3:1]};
      r[i*4 +: 4] = (c > lvl) ? c - lvl : 4'd0;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_fs = 0; m_L = 4'd0; m_rs = 4'd0; m_rps = 4'd0; m_vsp = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] st, input logic vs);
    logic chg, ft;
    chg = (m_rs != m_rps);
    ft  = m_vsp && !vs;
`ifdef VGA_PIXEL_PIPE_FADE_EN
    case (m_fs)
      0: begin m_L = 4'd0; if (chg) m_fs = 1; end
      1: if (ft) begin
           if (m_L == 4'd15) begin m_fs = 2; m_L = 4'd14; end
           else m_L = m_L + 4'd1;
         end
      2: if (chg) m_fs = 1;
         else if (ft) begin
           if (m_L == 4'd0) m_fs = 0;
           else m_L = m_L - 4'd1;
         end
      default: m_fs = 0;
    endcase
`else
    if (chg && ft) m_L = 4'd0;
`endif
    m_rps = m_rs; m_rs = st; m_vsp = vs;
  endtask

  // One pixel transaction: program the ROM word, drive inputs for one
  // pix_en tick, then compare the output owed from the previous tick.
  task automatic pix(input logic [11:0] d, input logic v, input logic nb,
                     input logic dk, input logic hs, input logic vs,
                     input logic [3:0] st);
    exp_t e;
    rom_mem[next_addr[7:0]] = d;
    pixel_addr = next_addr;
    next_addr  = next_addr + 17'd1;
    valid = v; notBlank = nb; isDark = dk; hsync_in = hs; vsync_in = vs; state = st;
    model_step(st, vs);
    e.rgb = model_rgb(d, v, nb, dk, m_L); e.hs = hs; e.vs = vs;
    sb.push_back(e);
    pix_en = 1'b1;
    @(posedge clk); #1;
    pix_en = 1'b0;
    if (sb.size() >= 2) begin
      e = sb.pop_front();
      checks++;
      if ({vgaRed, vgaGreen, vgaBlue, hsync, vsync} !== {e.rgb, e.hs, e.vs}) begin
        errors++;
        $display("FAIL pixel: got rgb=%h hs=%b vs=%b, required rgb=%h hs=%b vs=%b",
                 {vgaRed, vgaGreen, vgaBlue}, hsync, vsync, e.rgb, e.hs, e.vs);
      end
    end
    checks++;
    if (fade_busy !== (m_fs != 0)) begin
      errors++;
      $display("FAIL fade_busy: got %b, required %b", fade_busy, (m_fs != 0));
    end
    $display("pix addr=%05h data=%h v=%b nb=%b dk=%b hs=%b vs=%b st=%0d out=%h busy=%b",
             pixel_addr, d, v, nb, dk, hs, vs, st, {vgaRed, vgaGreen, vgaBlue}, fade_busy);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [11:0] d, input logic [3:0] st);
    pix(d, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, st);
    pix(d, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, st);
  endtask

  task automatic restart_after_reset();
    sb.delete();
    model_reset();
    begin
      exp_t e;
      e.rgb = 12'h000; e.hs = 1'b1; e.vs = 1'b1;
      sb.push_back(e);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; pix_en = 1'b1; valid = 1'b1; notBlank = 1'b1; isDark = 1'b0;
    hsync_in = 1'b0; vsync_in = 1'b0; pixel_addr = 17'h1ABCD; state = 4'd3;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({vgaRed, vgaGreen, vgaBlue} !== 12'h000) begin
      errors++; $display("FAIL reset_rgb: got %h, required 000", {vgaRed, vgaGreen, vgaBlue});
    end
    checks++;
    if ({hsync, vsync} !== 2'b11) begin
      errors++; $display("FAIL reset_sync: got %b%b, required 11", hsync, vsync);
    end
    checks++;
    if (rom_addr !== 17'd0) begin
      errors++; $display("FAIL reset_rom_addr: got %h, required 0", rom_addr);
    end
    checks++;
    if (fade_busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b, required 0", fade_busy);
    end
    rst = 1'b0; pix_en = 1'b0; state = 4'd0;
    restart_after_reset();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    next_addr = 17'h00123;
    pix(12'hABC, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
    checks++;
    if (rom_addr !== 17'h00123) begin
      errors++; $display("FAIL rom_addr: got %h, required 00123", rom_addr);
    end
    pix(12'h555, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
    checks++;
    if ({vgaRed, vgaGreen, vgaBlue, hsync, vsync} !== {12'hABC, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL latency_abc: got rgb=%h hs=%b vs=%b, required ABC 0 1",
               {vgaRed, vgaGreen, vgaBlue}, hsync, vsync);
    end
    pix(12'h123, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    pix(12'h9F0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0);
  endtask

  task automatic test_blank();
    pix(12'hF0F, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0);
    pix(12'hFFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0);
    checks++;
    if ({vgaRed, vgaGreen, vgaBlue} !== 12'h000) begin
      errors++; $display("FAIL transparent: got %h, required 000", {vgaRed, vgaGreen, vgaBlue});
    end
    pix(12'hFFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
    pix(12'hF0E, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0);
  endtask

  task automatic test_dark();
    pix(12'hE84, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0);
    pix(12'hFFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0);
    checks++;
    if ({vgaRed, vgaGreen, vgaBlue} !== 12'h742) begin
      errors++; $display("FAIL dark_e84: got %h, required 742", {vgaRed, vgaGreen, vgaBlue});
    end
    pix(12'h000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0);
  endtask

`ifdef VGA_PIXEL_PIPE_FADE_EN
  task automatic test_fade_sequence();
    pix(12'hFFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd2);
    pix(12'hFFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd2);
    checks++;
    if (fade_busy !== 1'b1) begin
      errors++; $display("FAIL fade_start: got %b, required 1", fade_busy);
    end
    for (int f = 1; f <= 31; f++) begin
      frame(12'hFFF, 4'd2);
      if (f == 15) begin
        pix(12'hFFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd2);
        checks++;
        if ({vgaRed, vgaGreen, vgaBlue} !== 12'h000) begin
          errors++; $display("FAIL fade_full: got %h, required 000", {vgaRed, vgaGreen, vgaBlue});
        end
      end
      if (f == 30) begin
        checks++;
        if (fade_busy !== 1'b1) begin
          errors++; $display("FAIL fade_30: got %b, required 1", fade_busy);
        end
      end
    end
    checks++;
    if (fade_busy !== 1'b0) begin
      errors++; $display("FAIL fade_31: got %b, required 0", fade_busy);
    end
  endtask

  task automatic test_fade_in_restart();
    pix(12'hFFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd3);
    pix(12'hFFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd3);
    for (int f = 0; f < 24; f++) frame(12'hFFF, 4'd3);
    pix(12'hFFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd4);
    pix(12'hFFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd4);
    checks++;
    if ({vgaRed, vgaGreen, vgaBlue} !== 12'h999) begin
      errors++; $display("FAIL fade_l6: got %h, required 999", {vgaRed, vgaGreen, vgaBlue});
    end
    frame(12'hFFF, 4'd4);
    pix(12'hFFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd4);
    checks++;
    if ({vgaRed, vgaGreen, vgaBlue} !== 12'h888) begin
      errors++; $display("FAIL fade_restart_l7: got %h, required 888", {vgaRed, vgaGreen, vgaBlue});
    end
    checks++;
    if (fade_busy !== 1'b1) begin
      errors++; $display("FAIL fade_restart_busy: got %b, required 1", fade_busy);
    end
  endtask

  task automatic test_reset_mid_fade();
    rst = 1'b1; state = 4'd0;
    @(posedge clk); #1;
    checks++;
    if ({fade_busy, hsync, vsync, vgaRed, vgaGreen, vgaBlue} !== {3'b011, 12'h000}) begin
      errors++;
      $display("FAIL reset_mid_fade: got busy=%b hs=%b vs=%b rgb=%h, required 0 1 1 000",
               fade_busy, hsync, vsync, {vgaRed, vgaGreen, vgaBlue});
    end
    rst = 1'b0;
    restart_after_reset();
    repeat (3) @(posedge clk); #1;
    pix(12'hFFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0);
    pix(12'hFFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
    checks++;
    if ({vgaRed, vgaGreen, vgaBlue} !== 12'hFFF) begin
      errors++; $display("FAIL no_residual: got %h, required FFF", {vgaRed, vgaGreen, vgaBlue});
    end
    pix(12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
  endtask
`else
  task automatic test_fade_disabled();
    pix(12'hFFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd2);
    pix(12'hFFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd3);
    for (int f = 0; f < 4; f++) frame(12'hFFF, 4'd3);
    checks++;
    if (fade_busy !== 1'b0) begin
      errors++; $display("FAIL busy_disabled: got %b, required 0", fade_busy);
    end
    pix(12'hFFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd3);
    checks++;
    if ({vgaRed, vgaGreen, vgaBlue} !== 12'hFFF) begin
      errors++; $display("FAIL undimmed: got %h, required FFF", {vgaRed, vgaGreen, vgaBlue});
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) rom_mem[i] = 12'h000;
    next_addr = 17'd0;
    model_reset();
    rst = 1'b1; pix_en = 1'b0; valid = 1'b0; notBlank = 1'b0; isDark = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b1; pixel_addr = 17'd0; state = 4'd0;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_blank();
    test_dark();
`ifdef VGA_PIXEL_PIPE_FADE_EN
    test_fade_sequence();
    test_fade_in_restart();
    test_reset_mid_fade();
`else
    test_fade_disabled();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
